// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: one outstanding memory request, decode hold, redirect squash
// Fields of each accepted word are registered toward decode; a redirect always wins.
module fetch_unit (
   input  logic        clock_i,
   input  logic        resetn_i,
   input  logic        enable_i,
   input  logic        stall_i,
   input  logic        branchValid_i,
   input  logic [15:0] branchTarget_i,
   output logic        memReq_o,
   output logic [15:0] memAddr_o,
   input  logic        memAck_i,
   input  logic [31:0] memData_i,
   output logic        enable_o,
   output logic        isBranch_o,
   output logic        instructionFormat_o,
   output logic [6:0]  opcode_o,
   output logic [4:0]  primOperand_o,
   output logic [15:0] secOperand_o,
   output logic [15:0] pc_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t      state;
   logic [15:0] pc;
   logic        drop;

   logic unused_reserved;
   assign unused_reserved = ^memData_i[1:0];

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state               <= IDLE;
         pc                  <= 16'h0000;
         drop                <= 1'b0;
         memReq_o            <= 1'b0;
         memAddr_o           <= 16'h0000;
         enable_o            <= 1'b0;
         isBranch_o          <= 1'b0;
         instructionFormat_o <= 1'b0;
         opcode_o            <= 7'h00;
         primOperand_o       <= 5'h00;
         secOperand_o        <= 16'h0000;
         pc_o                <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (branchValid_i) begin
                  pc <= branchTarget_i;
               end else if (enable_i) begin
                  state     <= FETCH;
                  memReq_o  <= 1'b1;
                  memAddr_o <= pc;
               end
            end
            FETCH: begin
               if (branchValid_i) begin
                  pc <= branchTarget_i;
                  // Coincident ack retires the request now; otherwise its data is discarded later.
                  if (memAck_i) begin
                     state    <= IDLE;
                     memReq_o <= 1'b0;
                     drop     <= 1'b0;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (memAck_i) begin
                  memReq_o <= 1'b0;
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state               <= HOLD;
                     enable_o            <= 1'b1;
                     isBranch_o          <= memData_i[31];
                     instructionFormat_o <= memData_i[30];
                     opcode_o            <= memData_i[29:23];
                     primOperand_o       <= memData_i[22:18];
                     secOperand_o        <= memData_i[17:2];
                     pc_o                <= memAddr_o;
                     pc                  <= pc + 16'd1;
                  end
               end
            end
            HOLD: begin
               if (branchValid_i || !stall_i) begin
                  enable_o <= 1'b0;
                  if (branchValid_i) begin
                     pc <= branchTarget_i;
                  end
                  if (enable_i) begin
                     state     <= FETCH;
                     memReq_o  <= 1'b1;
                     memAddr_o <= branchValid_i ? branchTarget_i : pc;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
